sram_responder: RTL and testbench

//  Responder end of the core's inst_sram/data_sram interface: on-chip word memory serving the core's fetch and load/store ports.

---
 rtl/sram_responder_pkg.sv | 28 ++
 rtl/sram_responder_bank.sv | 37 +++
 rtl/sram_responder.sv | 115 +++++++++++
 tb/tb_sram_responder.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/sram_responder_pkg.sv
// rtl/sram_responder_pkg.sv - shared types, widths and byte-merge helper for the SRAM responder
package sram_responder_pkg;

    localparam int WORD_WD = 32;
    localparam int BE_WD   = 4;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } sram_state_t;

    // Lanes with be[i]=1 take new_word, the rest keep old_word.
    function automatic logic [WORD_WD-1:0] byte_merge(
        input logic [WORD_WD-1:0] old_word,
        input logic [WORD_WD-1:0] new_word,
        input logic [BE_WD-1:0]   be
    );
        logic [WORD_WD-1:0] merged;
        merged = old_word;
        for (int i = 0; i < BE_WD; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/sram_responder_bank.sv
// rtl/sram_responder_bank.sv - word array with read port A, read/byte-write port B and clear-write mux
module sram_responder_bank
    import sram_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = 16
)
(
    input  logic                  clk,
    input  logic                  clear_en,
    input  logic [DEPTH_LOG2-1:0] clear_idx,
    input  logic [DEPTH_LOG2-1:0] a_idx,
    output logic [WORD_WD-1:0]    a_rdata,
    input  logic [DEPTH_LOG2-1:0] b_idx,
    input  logic [BE_WD-1:0]      b_be,
    input  logic [WORD_WD-1:0]    b_wdata,
    output logic [WORD_WD-1:0]    b_rdata
);

    logic [WORD_WD-1:0] mem [2**DEPTH_LOG2];

    // The clear sequencer owns the write port; port B writes only happen in RUN.
    always_ff @(posedge clk) begin
        if (clear_en) begin
            mem[clear_idx] <= '0;
        end else begin
            for (int i = 0; i < BE_WD; i++) begin
                if (b_be[i]) begin
                    mem[b_idx][8*i +: 8] <= b_wdata[8*i +: 8];
                end
            end
        end
    end

    assign a_rdata = mem[a_idx];
    assign b_rdata = mem[b_idx];

endmodule

// File: rtl/sram_responder.sv
// rtl/sram_responder.sv - on-chip SRAM responder for inst/data ports; SRAM_RESP_RAW_FWD_EN enables write-first inst forwarding
module sram_responder
    import sram_responder_pkg::*;
#(
    parameter int          DEPTH_LOG2     = 16,
    parameter logic [31:0] BASE_ADDR      = 32'hBFC0_0000,
    parameter bit          CLEAR_ON_RESET = 1'b1
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         inst_sram_en,
    input  logic [3:0]   inst_sram_wen,
    input  logic [31:0]  inst_sram_addr,
    input  logic [31:0]  inst_sram_wdata,
    output logic [31:0]  inst_sram_rdata,
    input  logic         data_sram_en,
    input  logic [3:0]   data_sram_wen,
    input  logic [31:0]  data_sram_addr,
    input  logic [31:0]  data_sram_wdata,
    output logic [31:0]  data_sram_rdata,
    output logic         init_done,
    output logic         addr_err
);

    localparam int                    TAG_LO   = DEPTH_LOG2 + 2;
    localparam logic [DEPTH_LOG2-1:0] LAST_IDX = '1;

    sram_state_t           state;
    logic [DEPTH_LOG2-1:0] clear_cnt;

    logic                  run;
    logic                  i_hit;
    logic                  d_hit;
    logic [DEPTH_LOG2-1:0] i_idx;
    logic [DEPTH_LOG2-1:0] d_idx;
    logic                  d_wr;
    logic                  collide;
    logic [BE_WD-1:0]      b_be;
    logic [WORD_WD-1:0]    a_rdata;
    logic [WORD_WD-1:0]    b_rdata;
    logic [WORD_WD-1:0]    i_word;
    logic                  unused_bits;

    assign run   = (state == ST_RUN);
    assign i_hit = (inst_sram_addr[31:TAG_LO] == BASE_ADDR[31:TAG_LO]);
    assign d_hit = (data_sram_addr[31:TAG_LO] == BASE_ADDR[31:TAG_LO]);
    assign i_idx = inst_sram_addr[TAG_LO-1:2];
    assign d_idx = data_sram_addr[TAG_LO-1:2];

    assign d_wr    = run && data_sram_en && d_hit && (data_sram_wen != '0);
    assign b_be    = d_wr ? data_sram_wen : '0;
    assign collide = run && inst_sram_en && i_hit && d_wr && (i_idx == d_idx);

`ifdef SRAM_RESP_RAW_FWD_EN
    assign i_word = collide ? byte_merge(a_rdata, data_sram_wdata, data_sram_wen) : a_rdata;
    assign unused_bits = ^{inst_sram_wdata, inst_sram_addr[1:0], data_sram_addr[1:0]};
`else
    assign i_word = a_rdata;
    assign unused_bits = ^{inst_sram_wdata, inst_sram_addr[1:0], data_sram_addr[1:0], collide};
`endif

    sram_responder_bank #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_bank (
        .clk       (clk),
        .clear_en  (state == ST_CLEAR),
        .clear_idx (clear_cnt),
        .a_idx     (i_idx),
        .a_rdata   (a_rdata),
        .b_idx     (d_idx),
        .b_be      (b_be),
        .b_wdata   (data_sram_wdata),
        .b_rdata   (b_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            clear_cnt       <= '0;
            init_done       <= !CLEAR_ON_RESET;
            addr_err        <= 1'b0;
            inst_sram_rdata <= '0;
            data_sram_rdata <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    inst_sram_rdata <= '0;
                    data_sram_rdata <= '0;
                    clear_cnt       <= clear_cnt + 1'b1;
                    if (clear_cnt == LAST_IDX) begin
                        state     <= ST_RUN;
                        init_done <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // Inst-port writes are never performed; they only flag the error.
                    if (inst_sram_en) begin
                        inst_sram_rdata <= i_hit ? i_word : '0;
                        if (!i_hit || (inst_sram_wen != '0)) begin
                            addr_err <= 1'b1;
                        end
                    end
                    if (data_sram_en) begin
                        data_sram_rdata <= d_hit ? b_rdata : '0;
                        if (!d_hit) begin
                            addr_err <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_responder.sv
// tb/tb_sram_responder.sv - randomized self-checking bench for sram_responder against a word-array model
module tb_sram_responder;

    localparam int          DL   = 4;
    localparam int          NW   = 16;
    localparam logic [31:0] BASE = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ie = 1'b0, de = 1'b0;
    logic [3:0]  iwen = '0, dwen = '0;
    logic [31:0] iaddr = '0, iwdata = '0, daddr = '0, dwdata = '0;
    logic [31:0] irdata, drdata;
    logic        done, aerr;

    logic        rst2 = 1'b1;
    logic        ie2 = 1'b0, de2 = 1'b0;
    logic [3:0]  iwen2 = '0, dwen2 = '0;
    logic [31:0] iaddr2 = '0, iwdata2 = '0, daddr2 = '0, dwdata2 = '0;
    logic [31:0] irdata2, drdata2;
    logic        done2, aerr2;

    int total = 0;
    int bad   = 0;

    logic [31:0] mdl_mem [NW];
    logic [31:0] mdl_i, mdl_d;
    logic        mdl_err;

    always #5 clk = ~clk;

    sram_responder #(.DEPTH_LOG2(DL), .BASE_ADDR(BASE), .CLEAR_ON_RESET(1'b1)) dut (
        .clk(clk), .rst(rst),
        .inst_sram_en(ie), .inst_sram_wen(iwen), .inst_sram_addr(iaddr),
        .inst_sram_wdata(iwdata), .inst_sram_rdata(irdata),
        .data_sram_en(de), .data_sram_wen(dwen), .data_sram_addr(daddr),
        .data_sram_wdata(dwdata), .data_sram_rdata(drdata),
        .init_done(done), .addr_err(aerr)
    );

    sram_responder #(.DEPTH_LOG2(DL), .BASE_ADDR(BASE), .CLEAR_ON_RESET(1'b0)) dut2 (
        .clk(clk), .rst(rst2),
        .inst_sram_en(ie2), .inst_sram_wen(iwen2), .inst_sram_addr(iaddr2),
        .inst_sram_wdata(iwdata2), .inst_sram_rdata(irdata2),
        .data_sram_en(de2), .data_sram_wen(dwen2), .data_sram_addr(daddr2),
        .data_sram_wdata(dwdata2), .data_sram_rdata(drdata2),
        .init_done(done2), .addr_err(aerr2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic bit in_win(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'd64);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 9) == 0) return $urandom;
        return BASE + 32'($urandom_range(0, 63));
    endfunction

    // Called at a negedge: drive one request cycle, predict, then check after the posedge.
    task automatic cyc(input logic ie_, input logic [3:0] iwen_, input logic [31:0] ia,
                       input logic de_, input logic [3:0] dwen_, input logic [31:0] da,
                       input logic [31:0] dwd, input string tag);
        logic [31:0] m;
        ie = ie_; iwen = iwen_; iaddr = ia; iwdata = $urandom;
        de = de_; dwen = dwen_; daddr = da; dwdata = dwd;
        if (ie_) begin
            if (in_win(ia)) begin
                mdl_i = mdl_mem[widx(ia)];
`ifdef SRAM_RESP_RAW_FWD_EN
                if (de_ && dwen_ != 0 && in_win(da) && widx(da) == widx(ia)) begin
                    m = lane_mask(dwen_);
                    mdl_i = (mdl_i & ~m) | (dwd & m);
                end
`endif
            end else begin
                mdl_i = '0;
                mdl_err = 1'b1;
            end
            if (iwen_ != 0) mdl_err = 1'b1;
        end
        if (de_) begin
            if (in_win(da)) begin
                mdl_d = mdl_mem[widx(da)];
                m = lane_mask(dwen_);
                mdl_mem[widx(da)] = (mdl_d & ~m) | (dwd & m);
            end else begin
                mdl_d = '0;
                mdl_err = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check({tag, ".irdata"}, irdata, mdl_i);
        check({tag, ".drdata"}, drdata, mdl_d);
        check({tag, ".addr_err"}, 32'(aerr), 32'(mdl_err));
        @(negedge clk);
        ie = 1'b0; de = 1'b0; iwen = '0; dwen = '0;
    endtask

    // Called at a negedge with rst low: run the clear window with bogus requests pending.
    task automatic clear_window(input string tag);
        ie = 1'b1; iaddr = 32'h8000_0000;
        de = 1'b1; dwen = 4'hF; daddr = BASE; dwdata = 32'hDEAD_BEEF;
        for (int c = 1; c <= NW; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("%s.done%0d", tag, c), 32'(done), 32'(c == NW));
            check($sformatf("%s.err%0d", tag, c), 32'(aerr), 32'd0);
            check($sformatf("%s.rd%0d", tag, c), irdata | drdata, 32'd0);
        end
        @(negedge clk);
        ie = 1'b0; de = 1'b0; dwen = '0;
        for (int w = 0; w < NW; w++) mdl_mem[w] = '0;
        mdl_i = '0; mdl_d = '0; mdl_err = 1'b0;
    endtask

    initial begin
        #1;
        check("rst.irdata", irdata, 32'd0);
        check("rst.drdata", drdata, 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.err", 32'(aerr), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_window("clr");

        for (int w = 0; w < NW; w++) cyc(1'b1, 4'h0, BASE + 32'(4*w), 1'b1, 4'h0, BASE + 32'(4*(NW-1-w)), 32'h0, "zero_rd");

        cyc(1'b1, 4'h0, 32'hBFC0_000C, 1'b1, 4'hF, 32'hBFC0_000C, 32'hCAFE_F00D, "raw");
        cyc(1'b1, 4'h0, 32'hBFC0_000C, 1'b0, 4'h0, 32'h0, 32'h0, "raw_next");
        check("raw_next.const", irdata, 32'hCAFE_F00D);

        cyc(1'b0, 4'h0, 32'h0, 1'b1, 4'hF, 32'hBFC0_0008, 32'h1122_3344, "be_w1");
        cyc(1'b0, 4'h0, 32'h0, 1'b1, 4'b0101, 32'hBFC0_0008, 32'hAABB_CCDD, "be_w2");
        cyc(1'b0, 4'h0, 32'h0, 1'b1, 4'h0, 32'hBFC0_000B, 32'h0, "be_rd");
        check("be_rd.const", drdata, 32'h11BB_33DD);
        cyc(1'b1, 4'h0, 32'hBFC0_0009, 1'b1, 4'h0, 32'hBFC0_0008, 32'h0, "both_rd");
        cyc(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, "hold");

        cyc(1'b0, 4'h0, 32'h0, 1'b1, 4'h0, 32'h8000_0000, 32'h0, "miss");
        check("miss.err_const", 32'(aerr), 32'd1);
        for (int k = 0; k < 5; k++) cyc(1'b1, 4'h0, BASE + 32'(4*k), 1'b1, 4'h0, BASE + 32'(4*k), 32'h0, "post_miss");

        for (int k = 0; k < 300; k++) begin
            cyc(1'($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0) ? 4'($urandom) : 4'h0, rand_addr(),
                1'($urandom_range(0, 3) != 0), 4'($urandom), rand_addr(), $urandom, "rand");
        end

        cyc(1'b1, 4'h0, BASE + 32'd4, 1'b1, 4'hF, BASE + 32'd20, 32'h1357_9BDF, "pre_rst");
        #2;
        rst = 1'b1;
        #1;
        check("async.irdata", irdata, 32'd0);
        check("async.drdata", drdata, 32'd0);
        check("async.done", 32'(done), 32'd0);
        check("async.err", 32'(aerr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        check("mid.done", 32'(done), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clear_window("reclr");
        for (int w = 0; w < NW; w++) cyc(1'b1, 4'h0, BASE + 32'(4*w), 1'b1, 4'h0, BASE + 32'(4*w), 32'h0, "reclr_rd");

        check("nc.rst_done", 32'(done2), 32'd1);
        rst2 = 1'b0;
        @(posedge clk);
        #1;
        check("nc.done", 32'(done2), 32'd1);
        check("nc.err0", 32'(aerr2), 32'd0);
        @(negedge clk);
        de2 = 1'b1; dwen2 = 4'hF; daddr2 = BASE + 32'd4; dwdata2 = 32'h5A5A_1234;
        @(negedge clk);
        de2 = 1'b0; dwen2 = 4'h0;
        ie2 = 1'b1; iwen2 = 4'h1; iaddr2 = BASE + 32'd4; iwdata2 = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        check("nc.err1", 32'(aerr2), 32'd1);
        check("nc.ird", irdata2, 32'h5A5A_1234);
        @(negedge clk);
        ie2 = 1'b0; iwen2 = 4'h0;
        de2 = 1'b1; daddr2 = BASE + 32'd4;
        @(posedge clk);
        #1;
        check("nc.unchanged", drdata2, 32'h5A5A_1234);
        @(negedge clk);
        de2 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
